// File: rtl/lcd_byte_arbiter_if.sv
// lcd_byte_arbiter_if: requester, LCD controller and status signals of the LCD byte arbiter.
interface lcd_byte_arbiter_if;
    logic       iReq0_Valid;
    logic [7:0] iReq0_Data;
    logic       oReq0_Full;
    logic       iReq1_Valid;
    logic [7:0] iReq1_Data;
    logic       oReq1_Full;
    logic       iLCD_Ready;
    logic [7:0] oLCD_Data;
    logic       oLCD_DataReady;
    logic       oGrant;
    logic       oBusy;
    logic [1:0] oOverflow;
    logic       oTimeout;
    logic       iClearError;

    modport slave (
        input  iReq0_Valid, iReq0_Data, iReq1_Valid, iReq1_Data, iLCD_Ready, iClearError,
        output oReq0_Full, oReq1_Full, oLCD_Data, oLCD_DataReady, oGrant, oBusy, oOverflow, oTimeout
    );

    modport master (
        output iReq0_Valid, iReq0_Data, iReq1_Valid, iReq1_Data, iLCD_Ready, iClearError,
        input  oReq0_Full, oReq1_Full, oLCD_Data, oLCD_DataReady, oGrant, oBusy, oOverflow, oTimeout
    );
endinterface

// File: rtl/lcd_byte_arbiter.sv
// lcd_byte_arbiter: round-robin sharing of one LCD data port between two FIFO-buffered byte producers,
// with a ready-drop timeout so a stalled controller cannot hang the issuing side.
module lcd_byte_arbiter #(
    parameter int FIFO_DEPTH  = 4,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic              Clock,
    input  logic              Reset,
    lcd_byte_arbiter_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int NW = AW + 1;
    localparam int CW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE} state_t;

    state_t        r_state, w_next;
    logic [7:0]    r_data;
    logic          r_strobe;
    logic          r_grant;
    logic [1:0]    r_overflow;
    logic          r_timeout;
    logic [CW-1:0] r_timer;

    logic [1:0]    w_valid, w_full, w_nempty, w_push, w_pop;
    logic [7:0]    w_wdata [2];
    logic [7:0]    w_rdata [2];
    logic          w_go, w_sel, w_expire;
    logic [CW-1:0] w_timer_nxt;

    assign w_valid    = {bus.iReq1_Valid, bus.iReq0_Valid};
    assign w_wdata[0] = bus.iReq0_Data;
    assign w_wdata[1] = bus.iReq1_Data;

    for (genvar i = 0; i < 2; i++) begin : g_fifo
        logic [7:0]    r_mem [FIFO_DEPTH];
        logic [AW-1:0] r_wptr, r_rptr;
        logic [NW-1:0] r_count;
        assign w_full[i]   = r_count == NW'(FIFO_DEPTH);
        assign w_nempty[i] = r_count != '0;
        assign w_push[i]   = w_valid[i] && !w_full[i];
        assign w_rdata[i]  = r_mem[r_rptr];
        always_ff @(posedge Clock) begin
            if (w_push[i]) r_mem[r_wptr] <= w_wdata[i];
        end
        always_ff @(posedge Clock or negedge Reset) begin
            if (!Reset) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
            end else begin
                if (w_push[i]) r_wptr <= r_wptr + 1'b1;
                if (w_pop[i]) r_rptr <= r_rptr + 1'b1;
                r_count <= r_count + NW'(w_push[i]) - NW'(w_pop[i]);
            end
        end
    end

    // With both FIFOs pending, the requester that did not win last time goes next.
    assign w_go        = r_state == IDLE && bus.iLCD_Ready && |w_nempty;
    assign w_sel       = &w_nempty ? ~r_grant : w_nempty[1];
    assign w_pop       = w_go ? (w_sel ? 2'b10 : 2'b01) : 2'b00;
    assign w_timer_nxt = r_timer + 1'b1;
    assign w_expire    = r_state == WAIT_ACK && bus.iLCD_Ready && w_timer_nxt == CW'(ACK_TIMEOUT);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      w_next = w_go ? ISSUE : IDLE;
            ISSUE:     w_next = WAIT_ACK;
            WAIT_ACK:  w_next = !bus.iLCD_Ready ? WAIT_DONE : (w_expire ? IDLE : WAIT_ACK);
            WAIT_DONE: w_next = bus.iLCD_Ready ? IDLE : WAIT_DONE;
            default:   w_next = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_data     <= 8'h00;
            r_strobe   <= 1'b0;
            r_grant    <= 1'b1;
            r_overflow <= 2'b00;
            r_timeout  <= 1'b0;
            r_timer    <= '0;
        end else begin
            r_strobe <= w_go;
            if (w_go) begin
                r_data  <= w_sel ? w_rdata[1] : w_rdata[0];
                r_grant <= w_sel;
            end
            r_overflow <= bus.iClearError ? 2'b00 : r_overflow | (w_valid & w_full);
            r_timeout  <= bus.iClearError ? 1'b0 : r_timeout | w_expire;
            r_timer    <= r_state == ISSUE ? '0 :
                          (r_state == WAIT_ACK && bus.iLCD_Ready) ? w_timer_nxt : r_timer;
        end
    end

    assign bus.oReq0_Full     = w_full[0];
    assign bus.oReq1_Full     = w_full[1];
    assign bus.oLCD_Data      = r_data;
    assign bus.oLCD_DataReady = r_strobe;
    assign bus.oGrant         = r_grant;
    assign bus.oBusy          = r_state != IDLE || |w_nempty;
    assign bus.oOverflow      = r_overflow;
    assign bus.oTimeout       = r_timeout;
endmodule

// File: tb/tb_lcd_byte_arbiter.sv
// tb_lcd_byte_arbiter: directed checks of issue order, overflow, timeout and mid-transfer reset.
module tb_lcd_byte_arbiter;
    localparam int FIFO_DEPTH  = 4;
    localparam int ACK_TIMEOUT = 255;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;
    logic auto_ctrl = 1'b0;
    int   low_cycles = 1;
    logic [8:0] strobes [$];

    lcd_byte_arbiter_if bus();

    lcd_byte_arbiter #(.FIFO_DEPTH(FIFO_DEPTH), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
        .Clock(clk),
        .Reset(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Every strobe is logged as {grant, data}.
    initial forever begin
        @(negedge clk);
        if (bus.oLCD_DataReady) strobes.push_back({bus.oGrant, bus.oLCD_Data});
    end

    // Controller model: drops ready one cycle after a strobe, raises it low_cycles later.
    initial forever begin
        @(negedge clk);
        if (auto_ctrl && bus.oLCD_DataReady) begin
            @(negedge clk);
            bus.iLCD_Ready = 1'b0;
            repeat (low_cycles) @(negedge clk);
            bus.iLCD_Ready = 1'b1;
        end
    end

    task automatic push(input logic v0, input logic [7:0] d0, input logic v1, input logic [7:0] d1);
        bus.iReq0_Valid = v0;
        bus.iReq0_Data  = d0;
        bus.iReq1_Valid = v1;
        bus.iReq1_Data  = d1;
        @(negedge clk);
        bus.iReq0_Valid = 1'b0;
        bus.iReq1_Valid = 1'b0;
    endtask

    task automatic do_reset();
        auto_ctrl = 1'b0;
        rst_n = 1'b0;
        bus.iReq0_Valid = 1'b0;
        bus.iReq1_Valid = 1'b0;
        bus.iReq0_Data  = 8'h00;
        bus.iReq1_Data  = 8'h00;
        bus.iClearError = 1'b0;
        bus.iLCD_Ready  = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        strobes.delete();
    endtask

    task automatic check_strobes(input string tag, input logic [8:0] exp [4]);
        check({tag, "_count"}, strobes.size(), 4);
        for (int i = 0; i < 4; i++)
            check($sformatf("%s_%0d", tag, i), i < strobes.size() ? strobes[i] : 9'h1ff, exp[i]);
    endtask

    initial begin
        logic [8:0] exp [4];
        do_reset();
        check("rst_data", bus.oLCD_Data, 8'h00);
        check("rst_strobe", bus.oLCD_DataReady, 1'b0);
        check("rst_grant", bus.oGrant, 1'b1);
        check("rst_busy", bus.oBusy, 1'b0);
        check("rst_ovf", bus.oOverflow, 2'b00);
        check("rst_to", bus.oTimeout, 1'b0);
        check("rst_full", {bus.oReq1_Full, bus.oReq0_Full}, 2'b00);

        // Single byte
        low_cycles = 20;
        auto_ctrl = 1'b1;
        push(1'b1, 8'h41, 1'b0, 8'h00);
        check("t1_busy_queued", bus.oBusy, 1'b1);
        check("t1_no_strobe_yet", bus.oLCD_DataReady, 1'b0);
        @(negedge clk);
        check("t1_strobe", bus.oLCD_DataReady, 1'b1);
        check("t1_data", bus.oLCD_Data, 8'h41);
        check("t1_grant", bus.oGrant, 1'b0);
        @(negedge clk);
        check("t1_strobe_off", bus.oLCD_DataReady, 1'b0);
        check("t1_data_hold", bus.oLCD_Data, 8'h41);
        repeat (30) @(negedge clk);
        check("t1_one_strobe", strobes.size(), 1);
        check("t1_idle", bus.oBusy, 1'b0);

        // Round-robin
        do_reset();
        bus.iLCD_Ready = 1'b0;
        push(1'b1, 8'h10, 1'b1, 8'h20);
        push(1'b1, 8'h11, 1'b1, 8'h21);
        repeat (3) @(negedge clk);
        check("t2_held", strobes.size(), 0);
        check("t2_busy", bus.oBusy, 1'b1);
        low_cycles = 1;
        auto_ctrl = 1'b1;
        bus.iLCD_Ready = 1'b1;
        repeat (30) @(negedge clk);
        exp = '{9'h010, 9'h120, 9'h011, 9'h121};
        check_strobes("t2_order", exp);
        check("t2_idle", bus.oBusy, 1'b0);

        // Overflow
        do_reset();
        bus.iLCD_Ready = 1'b0;
        for (int i = 1; i <= 3; i++) push(1'b0, 8'h00, 1'b1, 8'(i));
        check("t3_not_full", bus.oReq1_Full, 1'b0);
        push(1'b0, 8'h00, 1'b1, 8'h04);
        check("t3_full", bus.oReq1_Full, 1'b1);
        check("t3_no_ovf", bus.oOverflow, 2'b00);
        push(1'b0, 8'h00, 1'b1, 8'h05);
        check("t3_ovf", bus.oOverflow, 2'b10);
        check("t3_still_full", bus.oReq1_Full, 1'b1);
        low_cycles = 1;
        auto_ctrl = 1'b1;
        bus.iLCD_Ready = 1'b1;
        repeat (30) @(negedge clk);
        exp = '{9'h101, 9'h102, 9'h103, 9'h104};
        check_strobes("t3_order", exp);
        check("t3_drained", bus.oReq1_Full, 1'b0);
        check("t3_ovf_sticky", bus.oOverflow, 2'b10);

        // Timeout: ready is never dropped
        do_reset();
        push(1'b1, 8'h55, 1'b0, 8'h00);
        push(1'b1, 8'h66, 1'b0, 8'h00);
        check("t4_strobe", bus.oLCD_DataReady, 1'b1);
        check("t4_data", bus.oLCD_Data, 8'h55);
        repeat (ACK_TIMEOUT) @(negedge clk);
        check("t4_to_early", bus.oTimeout, 1'b0);
        @(negedge clk);
        check("t4_to_set", bus.oTimeout, 1'b1);
        check("t4_to_no_strobe", bus.oLCD_DataReady, 1'b0);
        @(negedge clk);
        check("t4_next_strobe", bus.oLCD_DataReady, 1'b1);
        check("t4_next_data", bus.oLCD_Data, 8'h66);
        bus.iLCD_Ready = 1'b0;
        repeat (2) @(negedge clk);
        bus.iLCD_Ready = 1'b1;
        repeat (3) @(negedge clk);
        check("t4_to_sticky", bus.oTimeout, 1'b1);
        check("t4_idle", bus.oBusy, 1'b0);
        bus.iClearError = 1'b1;
        @(negedge clk);
        bus.iClearError = 1'b0;
        check("t4_to_clear", bus.oTimeout, 1'b0);

        // Reset during WAIT_DONE with two bytes queued
        do_reset();
        low_cycles = 20;
        auto_ctrl = 1'b1;
        push(1'b1, 8'hA1, 1'b0, 8'h00);
        push(1'b1, 8'hA2, 1'b0, 8'h00);
        push(1'b1, 8'hA3, 1'b0, 8'h00);
        repeat (3) @(negedge clk);
        check("t5_pre_busy", bus.oBusy, 1'b1);
        check("t5_pre_ready", bus.iLCD_Ready, 1'b0);
        rst_n = 1'b0;
        #1;
        check("t5_rst_data", bus.oLCD_Data, 8'h00);
        check("t5_rst_grant", bus.oGrant, 1'b1);
        check("t5_rst_busy", bus.oBusy, 1'b0);
        check("t5_rst_strobe", bus.oLCD_DataReady, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        strobes.delete();
        repeat (40) @(negedge clk);
        check("t5_no_strobe", strobes.size(), 0);
        check("t5_idle", bus.oBusy, 1'b0);
        check("t5_empty", {bus.oReq1_Full, bus.oReq0_Full}, 2'b00);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
